// File: rtl/mux_pipe.sv
// mux_pipe: registered NUM_IN:1 channel select behind a valid/ready handshake.
// Defining MUX_PIPE_SKID_EN adds a one-entry skid register so in_ready comes from a flop.
module mux_pipe #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  beat_t w_beat;
  beat_t w_out_src;
  beat_t r_out;
  logic  r_out_valid;
  logic  w_in_xfer;
  logic  w_out_xfer;
  logic  w_load_out;

  // Beat as captured: selected channel, or zero data with err for an out-of-range select.
  always_comb begin
    w_beat      = '0;
    w_beat.sel  = sel;
    w_beat.err  = (32'(sel) >= NUM_IN);
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (sel == SEL_W'(k)) begin
        w_beat.data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  assign out_data  = r_out.data;
  assign out_sel   = r_out.sel;
  assign out_err   = r_out.err;
  assign out_valid = r_out_valid;

`ifdef MUX_PIPE_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  beat_t  r_skid;
  logic   r_in_ready;
  logic   w_load_skid;
  logic   w_out_from_skid;

  assign in_ready  = r_in_ready & ~flush;
  assign w_out_src = w_out_from_skid ? r_skid : w_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = S_ONE;
            w_load_out  = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_xfer && out_ready) begin
            w_load_out = 1'b1;
          end else if (w_in_xfer) begin
            // Output stalled: park the newer beat behind it.
            w_state_nxt = S_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt     = S_ONE;
            w_load_out      = 1'b1;
            w_out_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_beat;
    end
  end

`else

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  assign in_ready  = (~r_out_valid | out_ready) & ~flush;
  assign w_out_src = w_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = S_FULL;
            w_load_out  = 1'b1;
          end
        end
        S_FULL: begin
          if (w_in_xfer) begin
            w_load_out = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

`endif

  // Output stage; data keeps its last value when emptied, only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_load_out) begin
        r_out <= w_out_src;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed vector table plus hand sequences for stall, flush, reset and skid cases.
module tb_mux_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [9:0]  in_data = '0;
  logic [0:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  out_data;
  logic [0:0]  out_sel;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [14:0] in_data3 = '0;
  logic [1:0]  sel3 = '0;
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [4:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_err3;
  logic        out_valid3;
  logic        out_ready3 = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_sel(out_sel3),
    .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic [0:0] sl;
    logic [9:0] din;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [4:0] od;
    logic [0:0] os;
    logic       oe;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  sent;
    int  rcvd;
    logic acc;
    logic hold;
    logic [4:0] hd;

    //          fl    iv    sl    din               ordy  ir    ov    od     os    oe
    tbl[0]  = '{1'b0, 1'b1, 1'b1, {5'h1A, 5'h03}, 1'b1, 1'b1, 1'b1, 5'h1A, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, {5'h1A, 5'h03}, 1'b1, 1'b1, 1'b1, 5'h03, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, {5'h1A, 5'h03}, 1'b1, 1'b1, 1'b0, 5'h03, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, {5'h11, 5'h0F}, 1'b0, 1'b1, 1'b1, 5'h0F, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, {5'h11, 5'h0F}, 1'b0, 1'b0, 1'b0, 5'h0F, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, {5'h11, 5'h0F}, 1'b1, 1'b1, 1'b0, 5'h0F, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, {5'h1F, 5'h00}, 1'b1, 1'b1, 1'b1, 5'h1F, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, {5'h1F, 5'h00}, 1'b1, 1'b0, 1'b0, 5'h1F, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, {5'h15, 5'h0A}, 1'b1, 1'b1, 1'b1, 5'h0A, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, {5'h15, 5'h0A}, 1'b1, 1'b1, 1'b1, 5'h15, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, {5'h15, 5'h0A}, 1'b1, 1'b1, 1'b0, 5'h15, 1'b1, 1'b0};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 32'({out_valid, out_data, out_sel, out_err}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after release", 32'(in_ready), 32'(1));

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      sel       = tbl[i].sl;
      in_data   = tbl[i].din;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out", i),
            32'({out_valid, out_data, out_sel, out_err}),
            32'({tbl[i].ov, tbl[i].od, tbl[i].os, tbl[i].oe}));
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;

    // 8-beat stream against an alternating consumer.
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 64 && rcvd < 8; c++) begin
      @(negedge clk);
      out_ready = (c % 2 == 0);
      in_valid  = (sent < 8);
      sel       = 1'b0;
      in_data   = {5'h1F, 5'(sent)};
      #1;
      acc  = in_valid & in_ready;
      hold = out_valid & ~out_ready;
      hd   = out_data;
      if (out_valid && out_ready) begin
        check($sformatf("stream beat %0d", rcvd), 32'(out_data), 32'(rcvd));
        rcvd++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (hold) check("stream hold", 32'({out_valid, out_data}), 32'({1'b1, hd}));
    end
    check("stream received", 32'(rcvd), 32'(8));
    check("stream sent", 32'(sent), 32'(8));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stream drained", 32'(out_valid), 32'(0));

`ifdef MUX_PIPE_SKID_EN
    @(negedge clk);
    in_valid  = 1'b1;
    sel       = 1'b0;
    in_data   = {5'h00, 5'h05};
    out_ready = 1'b0;
    @(negedge clk);
    in_data = {5'h00, 5'h06};
    #1;
    check("skid ONE in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    check("skid TWO in_ready", 32'(in_ready), 32'(0));
    check("skid TWO out", 32'({out_valid, out_data}), 32'({1'b1, 5'h05}));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("skid second out", 32'({out_valid, out_data}), 32'({1'b1, 5'h06}));
    check("skid in_ready back", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    check("skid empty", 32'(out_valid), 32'(0));
`else
    @(negedge clk);
    in_valid  = 1'b1;
    sel       = 1'b0;
    in_data   = {5'h00, 5'h07};
    out_ready = 1'b1;
    @(negedge clk);
    in_data   = {5'h00, 5'h09};
    out_ready = 1'b0;
    #1;
    check("stall in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    check("stall hold", 32'({out_valid, out_data}), 32'({1'b1, 5'h07}));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall drain", 32'({out_valid, out_data}), 32'({1'b0, 5'h07}));
`endif

    // Asynchronous reset in the middle of a cycle with a beat held.
    @(negedge clk);
    in_valid  = 1'b1;
    sel       = 1'b1;
    in_data   = {5'h0E, 5'h01};
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset valid", 32'({out_valid, out_data}), 32'({1'b1, 5'h0E}));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async reset", 32'({out_valid, out_data, out_sel, out_err}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'(1));

    // Three-channel instance: out-of-range and top-channel selects.
    @(negedge clk);
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    sel3       = 2'd3;
    in_data3   = 15'h7FFF;
    #1;
    check("dut3 in_ready", 32'(in_ready3), 32'(1));
    @(posedge clk);
    #1;
    check("dut3 sel3 err", 32'({out_valid3, out_data3, out_sel3, out_err3}),
          32'({1'b1, 5'h00, 2'd3, 1'b1}));
    @(negedge clk);
    sel3     = 2'd2;
    in_data3 = {5'h0C, 5'h1F, 5'h1F};
    @(posedge clk);
    #1;
    check("dut3 sel2", 32'({out_valid3, out_data3, out_sel3, out_err3}),
          32'({1'b1, 5'h0C, 2'd2, 1'b0}));
    @(negedge clk);
    in_valid3 = 1'b0;
    @(posedge clk);
    #1;
    check("dut3 drain", 32'({out_valid3, out_data3}), 32'({1'b0, 5'h0C}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5, data width per input channel.
REQ-002 SHALL have parameter NUM_IN, default 2, number of input channels (legal 2..16).
REQ-003 SHALL have parameter SEL_W, default 1, select width, at least clog2(NUM_IN).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  NUM_IN*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SEL_W  channel select, sampled with the input beat.
REQ-008 SHALL have port in_valid  input  1  input beat offered.
REQ-009 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-010 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-011 SHALL have port out_data  output  WIDTH  selected, registered data.
REQ-012 SHALL have port out_sel  output  SEL_W  select value that produced out_data.
REQ-013 SHALL have port out_err  output  1  beat was captured with sel >= NUM_IN.
REQ-014 SHALL have port out_valid  output  1  output beat present.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the output beat.

Function
REQ-016 Input transfer SHALL occur on a rising edge with in_valid & in_ready; output transfer SHALL occur with out_valid & out_ready.
REQ-017 Captured beat SHALL be {channel[sel], sel, 0} for sel < NUM_IN, and {0, sel, 1} for sel >= NUM_IN.
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL show out_valid=1 after edge N when the output stage was empty or drained at edge N.
REQ-019 Without skid (see Configuration), state SHALL be EMPTY or FULL; in_ready = (~out_valid | out_ready) & ~flush, combinational.
REQ-020 EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL on simultaneous input and output transfer, with the new beat replacing the output.
REQ-021 out_data/out_sel/out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Beats SHALL leave in acceptance order; no beat is dropped or duplicated except by flush.
REQ-023 flush=1 SHALL force in_ready=0 and SHALL clear every held beat at that edge, whatever out_ready and in_valid are; out_valid=0 the next cycle.
REQ-024 out_data SHALL keep its last value after flush or drain; only out_valid marks validity.

Reset
REQ-025 rst_n=0 SHALL immediately clear out_valid, out_data, out_sel and out_err to 0 and force state EMPTY, independent of clk.
REQ-026 A beat in flight when reset asserts SHALL be lost; in_ready SHALL be 1 in the first cycle after release when flush=0 (no skid: out_valid=0).
REQ-027 Reset release SHALL be taken on the first rising edge after rst_n rises; no beat is accepted on that edge unless in_ready was 1.

Configuration
REQ-028 Macro MUX_PIPE_SKID_EN defined SHALL add a one-entry skid register; states EMPTY, ONE, TWO; in_ready = ~skid_full & ~flush, driven from a register (no combinational out_ready->in_ready path).
REQ-029 With MUX_PIPE_SKID_EN: ONE with input transfer and out_ready=0 -> TWO (new beat in skid); TWO with output transfer -> ONE (skid moves to output); full throughput of 1 beat/cycle SHALL be sustained.
REQ-030 Without MUX_PIPE_SKID_EN SHALL implement REQ-019/020 only, with no skid storage.

Verification
REQ-031 WIDTH=5, NUM_IN=2: sel=1, in_data={5'h1A,5'h03}, in_valid=1, out_ready=1 -> next cycle out_data=5'h1A, out_sel=1, out_err=0, out_valid=1.
REQ-032 NUM_IN=3, SEL_W=2, sel=3 -> out_data=0, out_sel=3, out_err=1.
REQ-033 Stream 8 beats 0..7 with out_ready toggling 1,0,1,0 -> out order 0..7, data held stable on every out_ready=0 cycle, none lost.
REQ-034 Output FULL holding 5'h0F, flush=1 with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, new beat not captured.
REQ-035 rst_n dropped mid-cycle while out_valid=1 -> out_valid=0 at once, before next edge; after release in_ready=1.
REQ-036 MUX_PIPE_SKID_EN: out_ready=0 and 2 beats sent -> state TWO, in_ready=0; out_ready=1 for 2 cycles -> both beats out in order, in_ready=1 again.
